prefix_sum_stage: RTL and testbench

//  Pipelined parallel-prefix carry/sum stage directly downstream of the preprocessing stage.

---
 rtl/prefix_sum_stage.sv | 93 +++++++++
 tb/tb_prefix_sum_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/prefix_sum_stage.sv
// rtl/prefix_sum_stage.sv - pipelined Kogge-Stone adder stage, one prefix level per register stage
module prefix_sum_stage #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_prim,
  input  logic [W-1:0] b_prim,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
);
  localparam int LEVELS = $clog2(W);

  logic         en;
  logic [W-1:0] b_eff;
  logic         v_q [LEVELS];
  logic [W-1:0] g_q [LEVELS];
  logic [W-1:0] p_q [LEVELS];
  logic [W-1:0] x_q [LEVELS];
  logic [W-1:0] g_d [LEVELS];
  logic [W-1:0] p_d [LEVELS];
  logic [W-1:0] g_fin;
  logic [W-1:0] sum_d;

  // One Kogge-Stone level; shifting by d lines up bit i with bit i-d, low d bits pass through.
  function automatic logic [W-1:0] lvl_g(input logic [W-1:0] g, input logic [W-1:0] p, input int d);
    lvl_g = g | (p & (g << d));
  endfunction

  function automatic logic [W-1:0] lvl_p(input logic [W-1:0] p, input int d);
    lvl_p = p & ((p << d) | ~({W{1'b1}} << d));
  endfunction

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;
  // Masking (not dropping) bit 0 keeps an X there from reaching any downstream logic.
  assign b_eff    = {b_prim[W-1:1], b_prim[0] & 1'b0};

  always_comb begin
    g_d[0] = a_prim & b_eff;
    p_d[0] = a_prim | b_eff;
    for (int k = 1; k < LEVELS; k++) begin
      g_d[k] = lvl_g(g_q[k-1], p_q[k-1], 1 << (k - 1));
      p_d[k] = lvl_p(p_q[k-1], 1 << (k - 1));
    end
    g_fin = lvl_g(g_q[LEVELS-1], p_q[LEVELS-1], 1 << (LEVELS - 1));
    sum_d = x_q[LEVELS-1] ^ {g_fin[W-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LEVELS; k++) begin
        v_q[k] <= 1'b0;
        g_q[k] <= '0;
        p_q[k] <= '0;
        x_q[k] <= '0;
      end
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else if (en) begin
      v_q[0] <= in_valid;
      if (in_valid) begin
        g_q[0] <= g_d[0];
        p_q[0] <= p_d[0];
        x_q[0] <= a_prim ^ b_eff;
      end
      for (int k = 1; k < LEVELS; k++) begin
        v_q[k] <= v_q[k-1];
        if (v_q[k-1]) begin
          g_q[k] <= g_d[k];
          p_q[k] <= p_d[k];
          x_q[k] <= x_q[k-1];
        end
      end
      out_valid <= v_q[LEVELS-1];
      if (v_q[LEVELS-1]) begin
        sum  <= sum_d;
        cout <= g_fin[W-1];
      end
    end
  end

  always_comb begin
    busy = out_valid;
    for (int k = 0; k < LEVELS; k++) busy = busy | v_q[k];
  end
endmodule

// File: tb/tb_prefix_sum_stage.sv
// tb/tb_prefix_sum_stage.sv - scoreboard bench for prefix_sum_stage against an arithmetic model
module tb_prefix_sum_stage;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [6:0] a_prim = '0;
  logic [6:0] b_prim = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [6:0] sum;
  logic       cout;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_acc    = 0;
  int n_out    = 0;
  int run_len  = 0;
  int max_run  = 0;
  int stall_cnt = 0;
  logic [7:0] sb [$];

  prefix_sum_stage #(.W(7)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_prim(a_prim), .b_prim(b_prim), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic [6:0] a, input logic [6:0] b);
    int r;
    r = int'(a) + 2 * int'(b >> 1);
    return 8'(r);
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Monitor: both handshakes are judged on the falling edge, ahead of the rising edge that commits them.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      run_len = 0;
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: got %0h expected none", {cout, sum});
        end else begin
          chk("result", int'({cout, sum}), int'(sb.pop_front()));
        end
      end else begin
        run_len = 0;
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(a_prim, b_prim));
        n_acc++;
      end
    end
  end

  task automatic send(input logic [6:0] a, input logic [6:0] b);
    int t;
    t = 0;
    a_prim   = a;
    b_prim   = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end
    stall_cnt += t;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!out_valid) begin
      n_checks++;
      $display("FAIL out_valid_timeout: got 0 expected 1");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int o0;
    int cyc;
    logic [7:0] e;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);

    // 1) single beat, latency 3
    out_ready = 1'b1;
    o0 = n_out;
    send(7'h05, 7'h0A);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("t1_latency", lat, 3);
    chk("t1_sum", sum, 'h0F);
    chk("t1_cout", cout, 0);
    idle(6);
    chk("t1_handshakes", n_out - o0, 1);

    // 2) wrap with carry out, bit 0 of b ignored
    send(7'h7F, 7'h02);
    in_valid = 1'b0;
    wait_valid();
    chk("t2a_sum", sum, 1);
    chk("t2a_cout", cout, 1);
    idle(6);
    send(7'h7F, 7'h03);
    in_valid = 1'b0;
    wait_valid();
    chk("t2b_sum", sum, 1);
    chk("t2b_cout", cout, 1);
    idle(6);

    // 3) 8 back-to-back beats
    stall_cnt = 0;
    max_run   = 0;
    for (int i = 0; i < 8; i++) send(7'($urandom), 7'($urandom));
    in_valid = 1'b0;
    idle(8);
    chk("t3_in_ready_stalls", stall_cnt, 0);
    chk("t3_consecutive_out", max_run, 8);

    // 4) fill with out_ready low, stall 5 cycles, drain
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(7'($urandom), 7'($urandom));
    a_prim = 7'h11;
    b_prim = 7'h22;
    wait_valid();
    e = sb[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_in_ready_low", in_ready, 0);
      chk("t4_out_valid_held", out_valid, 1);
      chk("t4_result_held", int'({cout, sum}), int'(e));
    end
    chk("t4_inflight", sb.size(), 4);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    max_run   = 0;
    out_ready = 1'b1;
    idle(8);
    chk("t4_drain_run", max_run, 4);
    chk("t4_busy_after", busy, 0);

    // 5) reset with 3 beats in flight
    for (int i = 0; i < 3; i++) send(7'($urandom), 7'($urandom));
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_sum", sum, 0);
    rst = 1'b0;
    o0 = n_out;
    idle(10);
    chk("t5_no_stale", n_out - o0, 0);

    // 6) random traffic, 10k accepted beats
    o0  = n_acc;
    cyc = 0;
    while ((n_acc - o0) < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      a_prim    = 7'($urandom);
      b_prim    = 7'($urandom);
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("t6_beats", n_acc - o0, 10000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(10);
    chk("final_sb_empty", sb.size(), 0);
    chk("final_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
